// File: rtl/alarm_pkg.sv
// Shared types and display constants for the multi-channel sensor alarm monitor.
package alarm_pkg;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    localparam int          CNT_W       = 4;
    localparam logic [15:0] HEX_SAFE    = 16'h5AFE;
    localparam logic [3:0]  SEV_ALERT   = 4'hA;
    localparam logic [3:0]  SEV_PREV    = 4'hC;
    localparam logic [3:0]  HEX_CH_MARK = 4'hE;

    function automatic logic [3:0] popcount_sat4(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return (n > 5'd15) ? 4'hF : n[3:0];
    endfunction

endpackage

// File: rtl/alarm_channel_persist.sv
// Per-channel persistence counter and alarm latch; a visit that reaches PERSIST latches,
// ack clears only channels not over threshold, so a same-cycle trip always beats ack.
module alarm_channel_persist
    import alarm_pkg::*;
#(
    parameter int PERSIST = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             visit,
    input  logic             over,
    input  logic             ack,
    output logic             latch,
    output logic [CNT_W-1:0] counter
);

    localparam logic [CNT_W-1:0] P = CNT_W'(PERSIST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            counter <= '0;
            latch   <= 1'b0;
        end else if (visit && over) begin
            if (counter != P) begin
                counter <= counter + 1'b1;
            end
            if (counter >= P - 1'b1) begin
                latch <= 1'b1;
            end
        end else if (!over && (visit || ack)) begin
            counter <= '0;
            if (ack) begin
                latch <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sensor_alarm_monitor.sv
// Round-robin threshold scanner over NCH channels with persistent, acknowledgeable alarms.
// Panel outputs are registered from the previous cycle's latch vector; disarm forces safe display.
module sensor_alarm_monitor
    import alarm_pkg::*;
#(
    parameter int             NCH      = 4,
    parameter int             W        = 4,
    parameter int             PERSIST  = 3,
    parameter logic [NCH-1:0] SEV_MASK = NCH'(4'b0011)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           interruptor,
    input  logic           ack,
    input  logic [NCH*W-1:0] sample,
    input  logic [NCH*W-1:0] thresh,
    output logic           LEDnormal,
    output logic           LEDalerta,
    output logic           LEDprevencion,
    output logic           alarma_alerta,
    output logic           alarma_prevencion,
    output logic [3:0]     hexa3,
    output logic [3:0]     hexa2,
    output logic [3:0]     hexa1,
    output logic [3:0]     hexa0
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t               state_q, state_d;
    logic                 clr;
    logic                 scan;
    logic [PW-1:0]        ptr_q;
    logic [NCH-1:0]       over;
    logic [NCH-1:0]       latch;
    logic [NCH*CNT_W-1:0] cnt_all;
    logic                 cnt_unused;

    logic                 any_lat;
    logic                 first_sev;
    logic [3:0]           first_ch;
    logic [15:0]          dec_hex;

    assign scan       = (state_q == SCAN);
    assign cnt_unused = ^cnt_all;

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (interruptor) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!interruptor) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            ptr_q <= '0;
        end else if (ptr_q == PW'(NCH - 1)) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_q + 1'b1;
        end
    end

    // Comparators run on every channel each cycle so ack can judge all of them at once.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign over[c] = (sample[c*W +: W] >= thresh[c*W +: W]);

        alarm_channel_persist #(
            .PERSIST (PERSIST)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr),
            .visit   (scan && (ptr_q == PW'(c))),
            .over    (over[c]),
            .ack     (scan && ack),
            .latch   (latch[c]),
            .counter (cnt_all[c*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        any_lat   = |latch;
        first_ch  = '0;
        first_sev = 1'b0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (latch[c]) begin
                first_ch  = 4'(c);
                first_sev = SEV_MASK[c];
            end
        end
        dec_hex = HEX_SAFE;
        if (any_lat) begin
            dec_hex = {first_sev ? SEV_ALERT : SEV_PREV, popcount_sat4(16'(latch)),
                       HEX_CH_MARK, first_ch};
        end
    end

    // Disarm drives the safe panel in the same edge that clears the latches.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            LEDnormal                  <= 1'b1;
            LEDalerta                  <= 1'b0;
            LEDprevencion              <= 1'b0;
            alarma_alerta              <= 1'b0;
            alarma_prevencion          <= 1'b0;
            {hexa3, hexa2, hexa1, hexa0} <= HEX_SAFE;
        end else begin
            LEDnormal                  <= ~any_lat;
            LEDalerta                  <= |(latch & SEV_MASK);
            LEDprevencion              <= |(latch & ~SEV_MASK);
            alarma_alerta              <= |(latch & SEV_MASK);
            alarma_prevencion          <= |(latch & ~SEV_MASK);
            {hexa3, hexa2, hexa1, hexa0} <= dec_hex;
        end
    end

endmodule

// File: tb/tb_sensor_alarm_monitor.sv
// Directed bench for sensor_alarm_monitor: behavioural model compared every cycle,
// plus hand-computed panel expectations at key points of each scenario.
module tb_sensor_alarm_monitor;

    localparam int             NCH     = 4;
    localparam int             W       = 4;
    localparam int             PERSIST = 3;
    localparam logic [NCH-1:0] SEV     = 4'b0011;
    localparam logic [20:0]    SAFE_V  = {1'b1, 4'b0000, 16'h5AFE};

    logic             clk = 1'b0;
    logic             reset, interruptor, ack;
    logic [NCH*W-1:0] sample, thresh;
    logic             LEDnormal, LEDalerta, LEDprevencion, alarma_alerta, alarma_prevencion;
    logic [3:0]       hexa3, hexa2, hexa1, hexa0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sensor_alarm_monitor #(
        .NCH(NCH), .W(W), .PERSIST(PERSIST), .SEV_MASK(SEV)
    ) dut (
        .clk(clk), .reset(reset), .interruptor(interruptor), .ack(ack),
        .sample(sample), .thresh(thresh),
        .LEDnormal(LEDnormal), .LEDalerta(LEDalerta), .LEDprevencion(LEDprevencion),
        .alarma_alerta(alarma_alerta), .alarma_prevencion(alarma_prevencion),
        .hexa3(hexa3), .hexa2(hexa2), .hexa1(hexa1), .hexa0(hexa0)
    );

    // Model: counters and latches per channel, panel derived from the latch list.
    int          m_cnt[NCH];
    bit          m_lat[NCH];
    int          m_ptr;
    bit          m_armed;
    bit          m_valid = 1'b0;
    logic [20:0] m_out;

    function automatic logic [20:0] decode_model();
        int n;
        int k;
        bit al;
        bit pv;
        logic [NCH-1:0] sev_v;
        n = 0; k = -1; al = 0; pv = 0; sev_v = SEV;
        for (int c = 0; c < NCH; c++) begin
            if (m_lat[c]) begin
                n++;
                if (k < 0) k = c;
                if (sev_v[c]) al = 1; else pv = 1;
            end
        end
        if (n == 0) return SAFE_V;
        return {1'b0, al, pv, al, pv, (sev_v[k] ? 4'hA : 4'hC), 4'((n > 15) ? 15 : n), 4'hE, 4'(k)};
    endfunction

    always @(posedge clk) begin
        bit ov[NCH];
        if (reset) begin
            m_armed = 0;
            m_ptr   = 0;
            for (int c = 0; c < NCH; c++) begin m_cnt[c] = 0; m_lat[c] = 0; end
            m_out   = SAFE_V;
            m_valid = 1'b1;
        end else if (!m_armed || !interruptor) begin
            m_out = SAFE_V;
            for (int c = 0; c < NCH; c++) begin m_cnt[c] = 0; m_lat[c] = 0; end
            m_ptr   = 0;
            m_armed = interruptor;
        end else begin
            m_out = decode_model();
            for (int c = 0; c < NCH; c++) begin
                ov[c] = (int'(sample[c*W +: W]) >= int'(thresh[c*W +: W]));
            end
            if (ov[m_ptr]) begin
                if (m_cnt[m_ptr] < PERSIST) m_cnt[m_ptr]++;
                if (m_cnt[m_ptr] == PERSIST) m_lat[m_ptr] = 1;
            end else begin
                m_cnt[m_ptr] = 0;
            end
            if (ack) begin
                for (int c = 0; c < NCH; c++) begin
                    if (!ov[c]) begin m_cnt[c] = 0; m_lat[c] = 0; end
                end
            end
            m_ptr = (m_ptr + 1) % NCH;
        end
    end

    always @(negedge clk) begin
        logic [20:0] got;
        if (m_valid) begin
            got = {LEDnormal, LEDalerta, LEDprevencion, alarma_alerta, alarma_prevencion,
                   hexa3, hexa2, hexa1, hexa0};
            n_chk++;
            if (got !== m_out) begin
                n_fail++;
                $display("FAIL model_compare t=%0t got=%h expected=%h", $time, got, m_out);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int c, input int s, input int t);
        sample[c*W +: W] = 4'(s);
        thresh[c*W +: W] = 4'(t);
    endtask

    task automatic rearm();
        reset       = 1'b1;
        sample      = '0;
        thresh      = {NCH{4'd8}};
        cyc(1);
        reset       = 1'b0;
        interruptor = 1'b1;
        cyc(1);
    endtask

    function automatic logic [15:0] hex_now();
        return {hexa3, hexa2, hexa1, hexa0};
    endfunction

    initial begin
        reset = 1'b1; interruptor = 1'b0; ack = 1'b0;
        sample = '0; thresh = {NCH{4'd8}};
        cyc(2);
        check("reset_hex", 32'(hex_now()), 32'h5AFE);
        check("reset_normal", 32'(LEDnormal), 32'd1);
        check("reset_alerta", 32'(LEDalerta), 32'd0);

        reset = 1'b0; interruptor = 1'b1;
        cyc(40);
        check("quiet_hex", 32'(hex_now()), 32'h5AFE);
        check("quiet_alarms", 32'({alarma_alerta, alarma_prevencion}), 32'd0);

        // ch1 at threshold: visits on SCAN edges 2, 6, 10
        rearm();
        set_ch(1, 12, 12);
        cyc(10);
        check("pre_trip_alerta", 32'(LEDalerta), 32'd0);
        cyc(1);
        check("trip_alerta", 32'({LEDalerta, alarma_alerta, LEDnormal}), 32'b110);
        check("trip_hex", 32'(hex_now()), 32'hA1E1);

        set_ch(2, 9, 5);
        cyc(16);
        check("two_hex", 32'(hex_now()), 32'hA2E1);
        check("two_leds", 32'({LEDalerta, LEDprevencion}), 32'b11);
        set_ch(1, 0, 12);
        ack = 1'b1; cyc(1); ack = 1'b0; cyc(1);
        check("ack_hex", 32'(hex_now()), 32'hC1E2);
        check("ack_alerta", 32'(LEDalerta), 32'd0);

        // ch0 glitch: over, over, below, then three fresh visits
        rearm();
        set_ch(0, 10, 8); cyc(8);
        set_ch(0, 2, 8);  cyc(4);
        set_ch(0, 10, 8); cyc(8);
        check("glitch_no_latch", 32'(LEDnormal), 32'd1);
        cyc(4);
        check("glitch_latch_hex", 32'(hex_now()), 32'hA1E0);
        ack = 1'b1; cyc(1); ack = 1'b0; cyc(1);
        check("ack_while_over", 32'(hex_now()), 32'hA1E0);

        interruptor = 1'b0; cyc(1);
        check("disarm_hex", 32'(hex_now()), 32'h5AFE);
        check("disarm_leds", 32'({LEDnormal, LEDalerta}), 32'b10);
        set_ch(0, 2, 8); interruptor = 1'b1; cyc(20);
        check("rearm_normal", 32'(LEDnormal), 32'd1);

        // reset mid-scan with ch0/ch1 latched and ch3 at count 2
        rearm();
        set_ch(0, 10, 8); set_ch(1, 12, 12); set_ch(3, 15, 8);
        cyc(11);
        check("mid_two_hex", 32'(hex_now()), 32'hA2E0);
        reset = 1'b1; set_ch(0, 0, 8); set_ch(1, 0, 12);
        cyc(1);
        check("mid_reset_hex", 32'(hex_now()), 32'h5AFE);
        check("mid_reset_normal", 32'(LEDnormal), 32'd1);
        reset = 1'b0;
        cyc(1);
        cyc(12);
        check("restart_no_early", 32'(LEDnormal), 32'd1);
        cyc(1);
        check("restart_trip_hex", 32'(hex_now()), 32'hC1E3);
        check("restart_prev", 32'({LEDprevencion, alarma_prevencion}), 32'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_alarm_monitor.md
Name: sensor_alarm_monitor

Overview:
- Parametrised successor of the single-temp/current/smoke alarm FSM.
- Scans NCH analogue sensor channels round-robin and compares each sample against a per-channel threshold.
- Requires PERSIST consecutive over-threshold visits before latching an alarm; latched alarms clear only on operator acknowledge.
- Drives the normal/alert/prevention LEDs, both alarm outputs and the 4-digit hex display on the panel board.

Parameters:
- NCH, 4, number of sensor channels (1..16).
- W, 4, sample/threshold width in bits.
- PERSIST, 3, consecutive over-threshold visits needed to latch (1..15).
- SEV_MASK, 4'b0011, per-channel severity: bit=1 alert class, bit=0 prevention class (NCH bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- interruptor  in  1  arm switch; 0 = disarmed.
- ack  in  1  operator acknowledge, level-sampled each cycle.
- sample  in  NCH*W  channel c at [c*W +: W], unsigned.
- thresh  in  NCH*W  channel c threshold at [c*W +: W], unsigned.
- LEDnormal, LEDalerta, LEDprevencion  out  1 each  panel LEDs.
- alarma_alerta, alarma_prevencion  out  1 each  buzzer drives.
- hexa3, hexa2, hexa1, hexa0  out  4 each  display nibbles, hexa3 leftmost.

Behaviour:
- Reset is synchronous, active-high, and wins over all other inputs. On reset:
  - state = IDLE, scan pointer = 0, all counters = 0, all latches = 0.
  - LEDnormal=1; all other LED/alarm outputs = 0; hex = 5,A,F,E.
- All outputs are registered and reflect the latch vector of the previous cycle (1-cycle latency).
- States:
  - IDLE: interruptor=0 holds here. Pointer, counters and latches are forced to 0; outputs equal the reset values. interruptor=1 moves to SCAN next cycle.
  - SCAN: each cycle, visit channel p = pointer; pointer increments and wraps NCH-1 -> 0.
    - over_p = sample_p >= thresh_p (equality counts as over).
    - If over_p: cnt_p saturating-increments at PERSIST; when cnt_p becomes PERSIST, latch_p <= 1.
    - Else: cnt_p <= 0.
    - Unvisited channels hold their counters.
    - interruptor=0 returns to IDLE next cycle; this clears latches (disarm clears alarms).
- Acknowledge:
  - ack=1 in SCAN clears latch_c and cnt_c for every channel c whose over_c is 0 that cycle. over_c is compared on all channels in parallel, not only the scanned one.
  - Channels still over keep their latch.
  - If a trip and ack land on the same channel in the same cycle, the trip wins (latch stays 1).
- Output decode from the latch vector L:
  - alarma_alerta = LEDalerta = |(L & SEV_MASK).
  - alarma_prevencion = LEDprevencion = |(L & ~SEV_MASK).
  - LEDnormal = (L == 0).
  - Hex when L == 0: 5,A,F,E.
  - Hex otherwise, with k = lowest-index latched channel:
    - hexa3 = A if SEV_MASK[k] else C.
    - hexa2 = popcount(L), saturating at F.
    - hexa1 = E.
    - hexa0 = k.
- Latency: a channel continuously over from cycle t latches on its PERSIST-th visit (at most t + PERSIST*NCH - 1). Outputs change one cycle later.
- NCH=1: pointer stays 0; every cycle is a visit.
- PERSIST=1: a single over visit latches.

Decomposition:
- Shared package alarm_pkg holds:
  - state enum {IDLE, SCAN}.
  - display constants HEX_SAFE = 16'h5AFE, SEV_ALERT = 4'hA, SEV_PREV = 4'hC, HEX_CH_MARK = 4'hE.
  - function popcount_sat4.
- Sub-module alarm_channel_persist, instantiated NCH times:
  - inputs clk, reset, clr (disarm), visit, over, ack.
  - outputs latch and counter.
  - implements the per-channel saturating counter and latch, including the trip-over-ack priority.
- Top level holds the FSM, pointer, comparators and the registered output decode.

Test Plan:
- Reset then interruptor=1, all samples below threshold for 40 cycles -> LEDnormal=1, both alarms 0, hex 5AFE throughout.
- NCH=4, PERSIST=3; ch1 (alert) sample=12, thresh=12 held -> latch on ch1's 3rd visit (cycle 10 of SCAN); next cycle LEDalerta=alarma_alerta=1, LEDnormal=0, hex A,1,E,1.
- ch1 latched, ch2 (prevention) also trips -> LEDalerta=LEDprevencion=1, hex A,2,E,1; drop ch1 below thresh and pulse ack 1 cycle -> hex C,1,E,2, LEDalerta=0.
- Glitch: ch0 over for 2 visits, below on the 3rd, over again -> no latch until 3 new consecutive visits; ack while ch0 still over -> latch held.
- Latched alarm active, interruptor=0 -> next cycle IDLE, all latches clear, outputs 5AFE/LEDnormal=1; re-arm with samples low -> stays normal.
- Assert reset mid-SCAN with two latches and partial counts -> next cycle reset values; counters restart from 0 (a trip needs a full PERSIST visits again).
